// File: rtl/comparator_6bit_serial_pkg.sv
// Shared Mini ALU definitions: the default operand width and the serial comparator state encoding.
package comparator_6bit_serial_pkg;

  localparam int ALU_WIDTH = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/comparator_6bit_serial_if.sv
// Request/result bundle for the bit-serial comparator; the master issues operands, the slave returns flags.
interface comparator_6bit_serial_if #(
  parameter int WIDTH = 6,
  parameter int IDX_W = $clog2(WIDTH)
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic             less_than;
  logic             equal;
  logic             greater_than;
  logic [IDX_W-1:0] diff_pos;

  modport master (
    output start, in1, in2,
    input  busy, done, less_than, equal, greater_than, diff_pos
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, less_than, equal, greater_than, diff_pos
  );

endinterface

// File: rtl/comparator_6bit_serial_bit.sv
// Single-bit magnitude cell: lt is high when i1 < i2; swap the inputs to obtain gt.
module comparator_6bit_serial_bit (
  input  logic i1,
  input  logic i2,
  output logic lt
);

  assign lt = ~i1 & i2;

endmodule

// File: rtl/comparator_6bit_serial.sv
// MSB-first serial magnitude compare, 2..WIDTH+1 cycles from start to done; start is ignored while busy.
module comparator_6bit_serial
  import comparator_6bit_serial_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input logic                    clk,
  input logic                    rst,
  comparator_6bit_serial_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDX_W-1:0] idx;

  logic             busy_q;
  logic             done_q;
  logic             lt_q;
  logic             eq_q;
  logic             gt_q;
  logic [IDX_W-1:0] pos_q;

  logic             bit_a;
  logic             bit_b;
  logic             lt_bit;
  logic             gt_bit;

  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

  comparator_6bit_serial_bit u_lt (
    .i1 (bit_a),
    .i2 (bit_b),
    .lt (lt_bit)
  );

  comparator_6bit_serial_bit u_gt (
    .i1 (bit_b),
    .i2 (bit_a),
    .lt (gt_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      pos_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.in1;
            b_r    <= bus.in2;
            idx    <= IDX_W'(WIDTH - 1);
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // First differing bit from the top decides the whole word.
          if (lt_bit || gt_bit) begin
            lt_q   <= lt_bit;
            gt_q   <= gt_bit;
            eq_q   <= 1'b0;
            pos_q  <= idx;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b1;
            pos_q  <= '0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.less_than    = lt_q;
  assign bus.equal        = eq_q;
  assign bus.greater_than = gt_q;
  assign bus.diff_pos     = pos_q;

endmodule

// File: tb/tb_comparator_6bit_serial.sv
// Directed bench for the serial comparator: latency, flags, ignored starts, back-to-back and async reset.
module tb_comparator_6bit_serial;

  localparam int WIDTH = 6;
  localparam int IDX_W = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   bsy;
  int   exp_pos;
  int   exp_lat;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  comparator_6bit_serial_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  comparator_6bit_serial #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // lat counts edges since the edge at which start was driven; bounded wait.
  task automatic wait_done(input int lat0, output int lat_o, output int busy_o);
    lat_o  = lat0;
    busy_o = 0;
    while (!bus.done && lat_o < 20) begin
      if (bus.busy) busy_o++;
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  task automatic check_res(input string tag, input logic l, input logic e, input logic g,
                           input int pos, input int lat_o, input int lat_e);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_lat"}, 32'(lat_o), 32'(lat_e));
    check({tag, "_lt"}, 32'(bus.less_than), 32'(l));
    check({tag, "_eq"}, 32'(bus.equal), 32'(e));
    check({tag, "_gt"}, 32'(bus.greater_than), 32'(g));
    check({tag, "_pos"}, 32'(bus.diff_pos), 32'(pos));
  endtask

  task automatic check_pulse(input string tag);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic int msb_diff(input logic [WIDTH-1:0] x);
    for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) return i;
    return 0;
  endfunction

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    @(posedge clk); #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("init_lt", 32'(bus.less_than), 32'd0);
    check("init_eq", 32'(bus.equal), 32'd0);
    check("init_gt", 32'(bus.greater_than), 32'd0);
    check("init_pos", 32'(bus.diff_pos), 32'd0);

    // MSB differs: shortest scan.
    launch(6'b100000, 6'b011111);
    check("msb_busy", 32'(bus.busy), 32'd1);
    wait_done(1, lat, bsy);
    check_res("msb", 1'b0, 1'b0, 1'b1, 5, lat, 2);
    check_pulse("msb");

    // Equal operands: full scan, busy for WIDTH cycles.
    launch(6'd13, 6'd13);
    wait_done(1, lat, bsy);
    check_res("eq13", 1'b0, 1'b1, 1'b0, 0, lat, 7);
    check("eq13_busy", 32'(bsy), 32'd6);
    check_pulse("eq13");

    launch(6'b010100, 6'b010110);
    wait_done(1, lat, bsy);
    check_res("bit1", 1'b1, 1'b0, 1'b0, 1, lat, 6);
    check_pulse("bit1");

    // Start while busy must not re-capture operands.
    launch(6'd5, 6'd5);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in1   = 6'd63;
    bus.in2   = 6'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(3, lat, bsy);
    check_res("ign", 1'b0, 1'b1, 1'b0, 0, lat, 7);
    // Start in the done cycle is accepted.
    launch(6'd63, 6'd0);
    check("b2b_done_fall", 32'(bus.done), 32'd0);
    check("b2b_busy_rise", 32'(bus.busy), 32'd1);
    wait_done(1, lat, bsy);
    check_res("b2b", 1'b0, 1'b0, 1'b1, 5, lat, 2);
    check_pulse("b2b");

    // Asynchronous reset mid-scan clears outputs without a clock edge.
    launch(6'd1, 6'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_lt", 32'(bus.less_than), 32'd0);
    check("arst_eq", 32'(bus.equal), 32'd0);
    check("arst_gt", 32'(bus.greater_than), 32'd0);
    check("arst_pos", 32'(bus.diff_pos), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    launch(6'd1, 6'd2);
    wait_done(1, lat, bsy);
    check_res("post_rst", 1'b1, 1'b0, 1'b0, 1, lat, 6);
    check_pulse("post_rst");

    // Random pairs against a reference scan.
    for (int n = 0; n < 200; n++) begin
      ra = WIDTH'($urandom_range(0, 63));
      rb = (n % 8 == 0) ? ra : WIDTH'($urandom_range(0, 63));
      exp_pos = msb_diff(ra ^ rb);
      exp_lat = WIDTH - exp_pos + 1;
      launch(ra, rb);
      wait_done(1, lat, bsy);
      check_res("rnd", ra < rb, ra == rb, ra > rb, exp_pos, lat, exp_lat);
      check_pulse("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
